// File: rtl/owm_pkg.sv
// owm_pkg: 1-wire master command codes, slot-engine states and default timing
package owm_pkg;
  localparam logic [1:0] CMD_W0  = 2'b00;
  localparam logic [1:0] CMD_W1  = 2'b01;
  localparam logic [1:0] CMD_RST = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_e;
  localparam int DEF_CDR    = 50;
  localparam int DEF_T_W1L  = 6;
  localparam int DEF_T_SMP  = 15;
  localparam int DEF_T_W0L  = 60;
  localparam int DEF_T_SLT  = 70;
  localparam int DEF_T_RSTL = 480;
  localparam int DEF_T_PSMP = 550;
  localparam int DEF_T_RSTT = 960;
  localparam int DEF_TW     = 10;
endpackage

// File: rtl/owm_prescaler.sv
// owm_prescaler: one-cycle tick every CDR clocks, restartable by clr (clk, rst_n, clr -> tick)
module owm_prescaler #(
  parameter int CDR = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int PW = $clog2(CDR);
  logic [PW-1:0] pc_q, pc_d;
  assign tick = pc_q == PW'(CDR - 1);
  always_comb pc_d = (clr || tick) ? '0 : pc_q + 1'b1;
  always_ff @(posedge clk) pc_q <= !rst_n ? '0 : pc_d;
endmodule

// File: rtl/owm_slot_tx.sv
// owm_slot_tx: 1-wire slot timing engine (req_vld/req_typ/req_rdy in, rsp_vld/rsp_bit out, owr_e/owr_i pad)
module owm_slot_tx
  import owm_pkg::*;
#(
  parameter int CDR    = DEF_CDR,
  parameter int T_W1L  = DEF_T_W1L,
  parameter int T_SMP  = DEF_T_SMP,
  parameter int T_W0L  = DEF_T_W0L,
  parameter int T_SLT  = DEF_T_SLT,
  parameter int T_RSTL = DEF_T_RSTL,
  parameter int T_PSMP = DEF_T_PSMP,
  parameter int T_RSTT = DEF_T_RSTT,
  parameter int TW     = DEF_TW
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_vld,
  input  logic [1:0] req_typ,
  output logic       req_rdy,
  output logic       rsp_vld,
  output logic       rsp_bit,
  output logic       owr_e,
  input  logic       owr_i
);
  if (CDR < 2 || !(T_W1L < T_SMP && T_SMP < T_SLT) || T_W0L >= T_SLT ||
      !(T_RSTL < T_PSMP && T_PSMP < T_RSTT) || T_RSTT > 2**TW - 1) begin : g_bad_params
    $error("owm_slot_tx: illegal timing parameters");
  end
  state_e state_q, state_d;
  logic [1:0] typ_q, typ_d;
  logic [TW-1:0] cnt_q, cnt_d, cnt_nx, tl, ts, te;
  logic owr_e_q, owr_e_d, rsp_bit_q, rsp_bit_d, clr, tick, is_rst, busy;
  owm_prescaler #(.CDR(CDR)) u_pre (.clk(clk), .rst_n(rst_n), .clr(clr), .tick(tick));
  assign is_rst = typ_q == CMD_RST;
  assign busy = state_q == S_LOW || state_q == S_HIGH;
  assign tl = is_rst ? TW'(T_RSTL) : typ_q == CMD_W0 ? TW'(T_W0L) : TW'(T_W1L);
  assign ts = is_rst ? TW'(T_PSMP) : TW'(T_SMP);
  assign te = is_rst ? TW'(T_RSTT) : TW'(T_SLT);
  assign cnt_nx = tick ? (&cnt_q ? cnt_q : cnt_q + 1'b1) : cnt_q;
  assign req_rdy = state_q == S_IDLE;
  assign rsp_vld = state_q == S_DONE;
  assign owr_e = owr_e_q;
  assign rsp_bit = rsp_bit_q;
  always_comb begin
    state_d = state_q;
    typ_d = typ_q;
    cnt_d = busy ? cnt_nx : cnt_q;
    owr_e_d = owr_e_q;
    clr = 1'b0;
    rsp_bit_d = busy && tick && cnt_nx == ts ? (is_rst ? ~owr_i : owr_i) : rsp_bit_q;
    case (state_q)
      S_IDLE: if (req_vld) begin
        typ_d = req_typ;
        clr = 1'b1;
        cnt_d = '0;
        owr_e_d = 1'b1;
        state_d = S_LOW;
      end
      S_LOW: if (tick && cnt_nx == tl) begin
        owr_e_d = 1'b0;
        state_d = S_HIGH;
      end
      S_HIGH: state_d = tick && cnt_nx == te ? S_DONE : S_HIGH;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      typ_q <= CMD_W0;
      cnt_q <= '0;
      owr_e_q <= 1'b0;
      rsp_bit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      typ_q <= typ_d;
      cnt_q <= cnt_d;
      owr_e_q <= owr_e_d;
      rsp_bit_q <= rsp_bit_d;
    end
  end
endmodule

// File: tb/tb_owm_slot_tx.sv
// tb_owm_slot_tx: randomized self-checking bench for owm_slot_tx against a cycle-timeline model
module tb_owm_slot_tx;
  import owm_pkg::*;
  localparam int CDR = 2;
  logic clk = 0, rst_n = 0, req_vld = 0, dev = 1;
  logic [1:0] req_typ = 2'b00;
  logic req_rdy, rsp_vld, rsp_bit, owr_e, owr_i;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  assign owr_i = ~owr_e & dev;
  owm_slot_tx #(.CDR(CDR)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_typ(req_typ), .req_rdy(req_rdy),
    .rsp_vld(rsp_vld), .rsp_bit(rsp_bit), .owr_e(owr_e), .owr_i(owr_i)
  );
  function automatic int tl_of(logic [1:0] t);
    return t == CMD_RST ? DEF_T_RSTL : t == CMD_W0 ? DEF_T_W0L : DEF_T_W1L;
  endfunction
  function automatic int ts_of(logic [1:0] t);
    return t == CMD_RST ? DEF_T_PSMP : DEF_T_SMP;
  endfunction
  function automatic int te_of(logic [1:0] t);
    return t == CMD_RST ? DEF_T_RSTT : DEF_T_SLT;
  endfunction
  task automatic run_cmd(input logic [1:0] typ, input int lo_s, input int lo_e, input bit hold, input string name);
    int tl, ts, te;
    bit e_owr, e_bit;
    tl = tl_of(typ) * CDR;
    ts = ts_of(typ) * CDR;
    te = te_of(typ) * CDR;
    e_bit = 0;
    checks++;
    if (req_rdy !== 1'b1) begin
      failures++;
      $display("FAIL %s req_rdy_at_accept got=%b exp=1", name, req_rdy);
    end
    req_vld = 1;
    req_typ = typ;
    dev = 1;
    @(posedge clk);
    for (int n = 1; n <= te + 2; n++) begin
      @(negedge clk);
      if (!hold) req_vld = 0;
      dev = !(n >= lo_s && n <= lo_e);
      e_owr = n <= tl;
      if (n == ts) e_bit = typ == CMD_RST ? !(!e_owr && dev) : (!e_owr && dev);
      checks += 3;
      if (owr_e !== e_owr) begin
        failures++;
        $display("FAIL %s owr_e cyc=%0d got=%b exp=%b", name, n, owr_e, e_owr);
      end
      if (rsp_vld !== (n == te + 1)) begin
        failures++;
        $display("FAIL %s rsp_vld cyc=%0d got=%b exp=%b", name, n, rsp_vld, n == te + 1);
      end
      if (req_rdy !== (n == te + 2)) begin
        failures++;
        $display("FAIL %s req_rdy cyc=%0d got=%b exp=%b", name, n, req_rdy, n == te + 2);
      end
      if (n == te + 1) begin
        checks++;
        if (rsp_bit !== e_bit) begin
          failures++;
          $display("FAIL %s rsp_bit cyc=%0d got=%b exp=%b", name, n, rsp_bit, e_bit);
        end
      end
    end
    dev = 1;
  endtask
  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_rdy, rsp_vld, rsp_bit, owr_e} !== 4'b1000) begin
      failures++;
      $display("FAIL reset rdy/vld/bit/owr_e got=%b exp=1000", {req_rdy, rsp_vld, rsp_bit, owr_e});
    end
    rst_n = 1;
  endtask
  task automatic test_basic();
    run_cmd(CMD_W1, 1, 0, 0, "write1");
    run_cmd(CMD_W0, 1, 0, 0, "write0");
    run_cmd(CMD_W1, 10, 60, 0, "read0");
    run_cmd(CMD_RST, 1000, 1400, 0, "rst_presence");
    run_cmd(CMD_RST, 1, 0, 0, "rst_nodev");
    run_cmd(2'b11, 10, 60, 0, "reserved_read0");
    run_cmd(2'b11, 1, 0, 0, "reserved_read1");
  endtask
  task automatic test_back_to_back();
    run_cmd(CMD_W1, 1, 0, 1, "b2b_first");
    run_cmd(CMD_W0, 1, 0, 0, "b2b_second");
    req_vld = 0;
  endtask
  task automatic test_mid_reset();
    req_vld = 1;
    req_typ = CMD_W0;
    @(posedge clk);
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      req_vld = 0;
    end
    rst_n = 0;
    @(negedge clk);
    checks++;
    if (owr_e !== 1'b0) begin
      failures++;
      $display("FAIL midreset owr_e got=%b exp=0", owr_e);
    end
    @(negedge clk);
    rst_n = 1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      checks += 3;
      if (rsp_vld !== 1'b0) begin
        failures++;
        $display("FAIL midreset rsp_vld cyc=%0d got=%b exp=0", n, rsp_vld);
      end
      if (req_rdy !== 1'b1) begin
        failures++;
        $display("FAIL midreset req_rdy cyc=%0d got=%b exp=1", n, req_rdy);
      end
      if (owr_e !== 1'b0) begin
        failures++;
        $display("FAIL midreset owr_e_after cyc=%0d got=%b exp=0", n, owr_e);
      end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      logic [1:0] t;
      int te, s, e;
      t = $urandom_range(0, 7) == 0 ? CMD_RST : 2'($urandom_range(0, 3));
      te = te_of(t) * CDR;
      s = $urandom_range(1, te);
      e = $urandom_range(0, 3) == 0 ? 0 : s + $urandom_range(0, te / 2);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_cmd(t, s, e, $urandom_range(0, 1) == 1, "random");
      req_vld = 0;
    end
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/owm_slot_tx.md
Name: owm_slot_tx

Overview:
- Transmit-side timing engine for the 1-wire master. It drives the open-drain line, where the pin-conditioning debouncer filters the line on the way in.
- Accepts one command per handshake: bus reset, write-0 slot, or write-1/read slot.
- Generates the timed low pulse, samples the line at the protocol sample point, and returns one response bit per command.
- Sits between the OWM register/control logic and the pad: owr_e enables the pad pull-down, and owr_i is the debounced line value.

Parameters:
- CDR, 50, clock cycles per 1 us tick; must be >= 2.
- T_W1L, 6, write-1/read low time in ticks.
- T_SMP, 15, bit-slot sample point in ticks.
- T_W0L, 60, write-0 low time in ticks.
- T_SLT, 70, total bit-slot length in ticks, including recovery.
- T_RSTL, 480, reset low time in ticks.
- T_PSMP, 550, presence sample point in ticks.
- T_RSTT, 960, total reset sequence length in ticks.
- TW, 10, tick counter width; must hold T_RSTT.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- req_vld  in  1  command valid
- req_typ  in  2  command type: 00 write-0, 01 write-1/read, 10 reset, 11 reserved (treated as write-1)
- req_rdy  out  1  block idle, command may be accepted
- rsp_vld  out  1  one-cycle response strobe
- rsp_bit  out  1  sampled line bit; for reset, presence (1 = device present)
- owr_e  out  1  pad pull-down enable (1 = drive line low)
- owr_i  in  1  debounced line value

Behaviour:
- Reset is synchronous and active-low: while rst_n=0 at a clk edge, all state clears and outputs take req_rdy=1, rsp_vld=0, rsp_bit=0, owr_e=0.
- Reset mid-operation: the line is released on the first edge with rst_n=0, the command is dropped, and no rsp_vld is issued.
- States: IDLE, LOW, HIGH, DONE.
- IDLE: req_rdy=1. A command is accepted on an edge with req_vld & req_rdy; that edge is cycle 0.
  - Latch the command type.
  - Restart the prescaler.
  - Clear the tick counter cnt.
  - Set owr_e=1 and go to LOW.
- Prescaler emits a one-cycle tick every CDR cycles; the first tick is at cycle CDR. cnt increments on each tick and saturates at all-ones.
- Low time TL and sample point TS by command:
  - write-0: TL=T_W0L, TS=T_SMP.
  - write-1/read: TL=T_W1L, TS=T_SMP.
  - reset: TL=T_RSTL, TS=T_PSMP.
- End time TE: T_SLT for bit slots, T_RSTT for reset.
- LOW: on the tick edge where cnt becomes TL, clear owr_e and go to HIGH. owr_e is therefore high for cycles 1..TL*CDR.
- Sampling happens in LOW or HIGH, on the tick edge where cnt becomes TS:
  - Bit slots: rsp_bit <= owr_i.
  - Reset: rsp_bit <= ~owr_i.
  - For write-0, TS < TL, so the sample reads the block's own low drive (expect 0); this is permitted and not an error.
- HIGH: on the tick edge where cnt becomes TE, go to DONE.
- DONE: lasts exactly one cycle, with rsp_vld=1 and rsp_bit holding the sampled value. Next state is IDLE.
- req_rdy is 0 in LOW, HIGH and DONE. It returns to 1 in the cycle after DONE.
- Slot duration from acceptance edge to the rsp_vld cycle is TE*CDR+1 cycles. The minimum gap between back-to-back commands is one idle cycle.
- req_vld while busy is ignored; no queuing.
- rsp_bit holds its value until the next sample point.
- owr_e is driven only from a flop (glitch-free pad control).
- Parameter legality is checked at elaboration, with an error if violated: T_W1L < T_SMP < T_SLT, T_W0L < T_SLT, and T_RSTL < T_PSMP < T_RSTT.

Decomposition:
- Package owm_pkg holds:
  - command encoding constants CMD_W0, CMD_W1, CMD_RST;
  - the state enum;
  - default timing constants, shared with the register block and the bench.
- Sub-module owm_prescaler (CDR parameter; ports clk, rst_n, clr, tick) is natural and reusable by the receive-side timing logic.

Test Plan:
- Common settings for all scenarios: CDR=2, default times, line model is wired-AND of owr_e and the device model.
- Write-1 with the line idle high: req_typ=01. Required response:
  - owr_e high for cycles 1..12;
  - rsp_vld at cycle 141 with rsp_bit=1;
  - req_rdy returns at cycle 142.
- Write-0: req_typ=00. Required response: owr_e high for cycles 1..120, rsp_bit=0, rsp_vld at cycle 141.
- Read-0 with the device holding the line low for cycles 10..60: req_typ=01. Required response: rsp_bit=0, and owr_e still releases at cycle 13.
- Reset with presence (device pulls low at cycles 1000..1400): req_typ=10. Required response: owr_e high for cycles 1..960, rsp_bit=1 at rsp_vld in cycle 1921. With no device, rsp_bit=0.
- Robustness:
  - req_vld held high while busy: a single command is accepted, and the next is accepted only at cycle 142.
  - rst_n=0 at cycle 50 of a write-0: owr_e is 0 from the next edge, no rsp_vld, and req_rdy=1 after reset.
